// File: rtl/instr_fetch_unit.sv
// PC + fetch stage: drives word-indexed imem, registers {instr, pc, pc+4}; 1-cycle pc->out latency.
// Holds output under !out_ready (pc stalls); redirects flush; misaligned/out-of-range pc parks in sticky FAULT.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);
    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] opc4_q, opc4_d;
    logic [31:0] faddr_q, faddr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        advance;
    logic        pc_bad;

    assign imem_addr = {2'b00, pc_q[31:2]};
    assign advance   = !valid_q || out_ready;
    // Alignment is only a concern for RESET_PC; every later pc is checked at redirect.
    assign pc_bad    = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        opc4_d  = opc4_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (valid_q && out_ready) begin
                cnt_d = cnt_q + 32'd1;
            end
            if (redirect_valid) begin
                valid_d = 1'b0;
                if (redirect_target[1:0] != 2'b00) begin
                    state_d = FAULT;
                    faddr_d = redirect_target;
                end else begin
                    pc_d = redirect_target;
                end
            end else if (advance) begin
                if (pc_bad) begin
                    state_d = FAULT;
                    faddr_d = pc_q;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_rdata;
                    opc_d   = pc_q;
                    opc4_d  = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            opc_q   <= 32'd0;
            opc4_q  <= 32'd4;
            faddr_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
            faddr_q <= faddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = opc_q;
    assign out_pc_plus4 = opc4_q;
    assign fault        = (state_q == FAULT);
    assign fault_addr   = faddr_q;
    assign fetch_count  = cnt_q;
endmodule
